// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - melody ROM autoplay sequencer arbitrating the piano key bus
module song_sequencer #(
  parameter int BEAT_TICKS = 8,
  parameter int GAP_TICKS  = 2,
  parameter int SONG_LEN   = 15
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       PLAY,
  input  logic       STOP,
  input  logic       LOOP,
  input  logic [7:0] sw,
  output logic [7:0] KEYS,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] NOTE_IDX
);

  // Counter must hold a full 3-beat note without wrapping.
  localparam int              CW       = $clog2(3 * BEAT_TICKS + 1);
  localparam logic [3:0]      LAST_IDX = 4'(SONG_LEN - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_play_q;

  logic          w_start;
  logic [3:0]    w_seq_idx;
  logic [7:0]    w_seq_keys;
  logic [7:0]    w_first_keys;
  logic [1:0]    w_beats_raw;
  logic [1:0]    w_beats;
  logic [CW-1:0] w_note_last;

  // Key field of the melody ROM (Ode to Joy); 8'h00 is a rest.
  function automatic logic [7:0] rom_keys(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_keys = 8'h20;
      4'd1:    rom_keys = 8'h20;
      4'd2:    rom_keys = 8'h10;
      4'd3:    rom_keys = 8'h08;
      4'd4:    rom_keys = 8'h08;
      4'd5:    rom_keys = 8'h10;
      4'd6:    rom_keys = 8'h20;
      4'd7:    rom_keys = 8'h40;
      4'd8:    rom_keys = 8'h80;
      4'd9:    rom_keys = 8'h80;
      4'd10:   rom_keys = 8'h40;
      4'd11:   rom_keys = 8'h20;
      4'd12:   rom_keys = 8'h20;
      4'd13:   rom_keys = 8'h40;
      4'd14:   rom_keys = 8'h40;
      default: rom_keys = 8'h00;
    endcase
  endfunction

  // Beat field of the melody ROM; the two held notes close each phrase.
  function automatic logic [1:0] rom_beats(input logic [3:0] idx);
    case (idx)
      4'd12:   rom_beats = 2'd2;
      4'd14:   rom_beats = 2'd2;
      default: rom_beats = 2'd1;
    endcase
  endfunction

  assign w_start      = PLAY & ~r_play_q;
  // Past the final entry the next note is always entry 0 (loop restart).
  assign w_seq_idx    = (NOTE_IDX == LAST_IDX) ? 4'd0 : NOTE_IDX + 4'd1;
  assign w_seq_keys   = rom_keys(w_seq_idx);
  assign w_first_keys = rom_keys(4'd0);
  assign w_beats_raw  = rom_beats(NOTE_IDX);
  assign w_beats      = (w_beats_raw == 2'd0) ? 2'd1 : w_beats_raw;
  assign w_note_last  = CW'({30'd0, w_beats} * BEAT_TICKS - 1);

  // Previous-sample register for PLAY edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_play_q <= 1'b0;
    end else begin
      r_play_q <= PLAY;
    end
  end

  // Playback FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      KEYS     <= 8'h00;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      NOTE_IDX <= 4'd0;
    end else begin
      DONE <= 1'b0;
      if (STOP) begin
        // Abort silences the bus for one edge before switches return.
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        KEYS     <= 8'h00;
        BUSY     <= 1'b0;
        NOTE_IDX <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state  <= S_NOTE;
              r_cnt    <= '0;
              NOTE_IDX <= 4'd0;
              KEYS     <= w_first_keys;
              BUSY     <= 1'b1;
            end else begin
              KEYS <= sw;
            end
          end
          S_NOTE: begin
            if (r_cnt == w_note_last) begin
              r_state <= S_GAP;
              r_cnt   <= '0;
              KEYS    <= 8'h00;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt <= '0;
              if ((NOTE_IDX != LAST_IDX) || LOOP) begin
                r_state  <= S_NOTE;
                NOTE_IDX <= w_seq_idx;
                KEYS     <= w_seq_keys;
              end else begin
                // Natural end: index stays on the last entry for inspection.
                r_state <= S_IDLE;
                BUSY    <= 1'b0;
                DONE    <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            KEYS    <= 8'h00;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
